// File: rtl/ibex_rf_writeback.sv
// Writeback stage in front of the register file write port.
// Holds one retiring instruction; loads/stores wait for the LSU.
module ibex_rf_writeback #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_wb_i,
    input  logic [1:0]           instr_type_wb_i,
    input  logic [4:0]           rf_waddr_id_i,
    input  logic [DataWidth-1:0] rf_wdata_id_i,
    input  logic                 rf_we_id_i,
    input  logic                 dummy_instr_id_i,
    input  logic                 lsu_resp_valid_i,
    input  logic                 lsu_resp_err_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    output logic                 ready_wb_o,
    output logic [4:0]           rf_waddr_wb_o,
    output logic [DataWidth-1:0] rf_wdata_wb_o,
    output logic                 rf_we_wb_o,
    output logic                 dummy_instr_wb_o,
    output logic                 rf_write_wb_o,
    output logic                 outstanding_load_wb_o,
    output logic                 instr_done_wb_o,
    output logic                 lsu_timeout_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOLD_REG = 2'd1;
    localparam logic [1:0] WAIT_LSU = 2'd2;

    localparam logic [1:0] T_REG   = 2'd0;
    localparam logic [1:0] T_LOAD  = 2'd1;
    localparam logic [1:0] T_STORE = 2'd2;

    localparam bit         WdogEn      = (TimeoutCycles != 0);
    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

    logic [1:0]           state_q, state_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic [1:0]           type_q, type_d;
    logic                 dummy_q, dummy_d;
    logic [7:0]           cnt_q, cnt_d;

    logic idle_st, hold_st, wait_st;
    logic resp, timeout, done, accept, is_load;
    logic [1:0] new_type;

    assign idle_st = (state_q == IDLE);
    assign hold_st = (state_q == HOLD_REG);
    assign wait_st = (state_q == WAIT_LSU);
    assign is_load = (type_q == T_LOAD);

    // A response on the expiry cycle takes priority over the watchdog.
    assign resp    = wait_st & lsu_resp_valid_i;
    assign timeout = WdogEn & wait_st & ~lsu_resp_valid_i
                   & (cnt_q == TimeoutLast);
    assign done    = hold_st | resp | timeout;
    assign accept  = en_wb_i & ready_wb_o;

    assign new_type = (instr_type_wb_i == 2'd3) ? T_REG : instr_type_wb_i;

    assign ready_wb_o            = idle_st | done;
    assign instr_done_wb_o       = done;
    assign lsu_timeout_o         = timeout;
    assign rf_waddr_wb_o         = waddr_q;
    assign rf_write_wb_o         = ~idle_st & we_q;
    assign outstanding_load_wb_o = wait_st & is_load;
    assign dummy_instr_wb_o      = ~idle_st & dummy_q;

    // Load data goes straight from the LSU to the write port.
    assign rf_we_wb_o    = (hold_st & we_q)
                         | (resp & is_load & we_q & ~lsu_resp_err_i);
    assign rf_wdata_wb_o = (resp & is_load) ? lsu_rdata_i : wdata_q;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        type_d  = type_q;
        dummy_d = dummy_q;
        cnt_d   = cnt_q;
        if (accept) begin
            waddr_d = rf_waddr_id_i;
            wdata_d = rf_wdata_id_i;
            we_d    = rf_we_id_i;
            type_d  = new_type;
            dummy_d = dummy_instr_id_i;
            cnt_d   = 8'd0;
            state_d = (new_type == T_LOAD || new_type == T_STORE)
                    ? WAIT_LSU : HOLD_REG;
        end else if (done) begin
            state_d = IDLE;
        end else if (wait_st && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            type_q  <= T_REG;
            dummy_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            type_q  <= type_d;
            dummy_q <= dummy_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    logic stray_ok_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stray_ok_q <= 1'b0;
        else         stray_ok_q <= timeout;
    end

    a_en_ready: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        en_wb_i |-> ready_wb_o);

    a_no_stray: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        lsu_resp_valid_i |-> (wait_st | stray_ok_q));
`endif

endmodule

// File: tb/tb_ibex_rf_writeback.sv
// Bench for ibex_rf_writeback: directed scenarios then random
// traffic, all compared against an instruction-level model.
module tb_ibex_rf_writeback;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, we, dm, rv, re;
    logic [1:0]  ty;
    logic [4:0]  wa;
    logic [31:0] wd, rd;

    logic        ready, o_we, o_dm, o_write, o_outld, o_done, o_to;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;

    int n_vec = 0;
    int n_err = 0;
    int n_chk = 0;

    // Model: at most one pending instruction plus its wait age.
    bit          h_valid;
    int          h_kind;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    bit          h_we, h_dm;
    int          h_age;

    bit          x_ready, x_we, x_dm, x_write, x_outld, x_done, x_to;
    logic [31:0] x_wdata;

    ibex_rf_writeback #(
        .DataWidth    (32),
        .TimeoutCycles(T)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .en_wb_i              (en),
        .instr_type_wb_i      (ty),
        .rf_waddr_id_i        (wa),
        .rf_wdata_id_i        (wd),
        .rf_we_id_i           (we),
        .dummy_instr_id_i     (dm),
        .lsu_resp_valid_i     (rv),
        .lsu_resp_err_i       (re),
        .lsu_rdata_i          (rd),
        .ready_wb_o           (ready),
        .rf_waddr_wb_o        (o_waddr),
        .rf_wdata_wb_o        (o_wdata),
        .rf_we_wb_o           (o_we),
        .dummy_instr_wb_o     (o_dm),
        .rf_write_wb_o        (o_write),
        .outstanding_load_wb_o(o_outld),
        .instr_done_wb_o      (o_done),
        .lsu_timeout_o        (o_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        h_valid = 0; h_kind = 0; h_addr = '0; h_data = '0;
        h_we = 0; h_dm = 0; h_age = 0;
    endtask

    function automatic bit pred_ready(input bit r);
        return !h_valid || h_kind == 0 || (h_kind != 0 && r)
            || (T != 0 && h_age + 1 == T);
    endfunction

    task automatic model_eval();
        x_done = 0; x_we = 0; x_to = 0; x_wdata = h_data;
        if (h_valid) begin
            if (h_kind == 0) begin
                x_done = 1; x_we = h_we;
            end else if (rv) begin
                x_done = 1;
                if (h_kind == 1) begin
                    x_we = h_we && !re; x_wdata = rd;
                end
            end else if (T != 0 && h_age + 1 == T) begin
                x_done = 1; x_to = 1;
            end
        end
        x_ready = !h_valid || x_done;
        x_write = h_valid && h_we;
        x_outld = h_valid && h_kind == 1;
        x_dm    = h_valid && h_dm;
    endtask

    task automatic model_update();
        if (en && x_ready) begin
            h_valid = 1;
            h_kind  = (ty == 2'd1) ? 1 : (ty == 2'd2) ? 2 : 0;
            h_addr  = wa; h_data = wd; h_we = we; h_dm = dm; h_age = 0;
        end else if (x_done) begin
            h_valid = 0;
        end else if (h_valid) begin
            h_age++;
        end
    endtask

    task automatic check_all();
        chk("ready",  32'(ready),   32'(x_ready));
        chk("waddr",  32'(o_waddr), 32'(h_addr));
        chk("wdata",  o_wdata,      x_wdata);
        chk("we",     32'(o_we),    32'(x_we));
        chk("dummy",  32'(o_dm),    32'(x_dm));
        chk("write",  32'(o_write), 32'(x_write));
        chk("outld",  32'(o_outld), 32'(x_outld));
        chk("done",   32'(o_done),  32'(x_done));
        chk("tmo",    32'(o_to),    32'(x_to));
    endtask

    task automatic step(input bit e, input logic [1:0] t,
                        input logic [4:0] a, input logic [31:0] d,
                        input bit w, input bit m, input bit r,
                        input bit er, input logic [31:0] rdat);
        @(negedge clk);
        en = e; ty = t; wa = a; wd = d; we = w; dm = m;
        rv = r; re = er; rd = rdat;
        #1;
        model_eval();
        check_all();
        model_update();
        n_vec++;
    endtask

    task automatic idle();
        step(0, 2'd0, 5'd0, 32'd0, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] a,
                         input logic [31:0] d, input bit m);
        step(1, t, a, d, 1, m, 0, 0, 32'd0);
    endtask

    task automatic respond(input logic [31:0] rdat, input bit er);
        step(0, 2'd0, 5'd0, 32'd0, 0, 0, 1, er, rdat);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        en = 0; ty = '0; wa = '0; wd = '0; we = 0; dm = 0;
        rv = 0; re = 0; rd = '0;
        #1;
        model_reset();
        model_eval();
        check_all();
        chk("rst_ready", 32'(ready), 32'd1);
        n_vec++;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bit r_rv, r_en;
        en = 0; ty = '0; wa = '0; wd = '0; we = 0; dm = 0;
        rv = 0; re = 0; rd = '0;
        model_reset();
        do_reset();

        issue(2'd0, 5'd5, 32'hDEADBEEF, 0);
        idle();
        chk("reg_wdata", o_wdata, 32'hDEADBEEF);
        chk("reg_we", 32'(o_we), 32'd1);
        chk("reg_ready", 32'(ready), 32'd1);

        issue(2'd1, 5'd7, 32'h0, 0);
        idle();
        chk("ld_busy", 32'(ready), 32'd0);
        idle();
        respond(32'h12345678, 0);
        chk("ld_wdata", o_wdata, 32'h12345678);
        chk("ld_we", 32'(o_we), 32'd1);

        issue(2'd1, 5'd8, 32'h0, 0);
        idle();
        respond(32'hCAFEF00D, 1);
        issue(2'd2, 5'd9, 32'h55, 0);
        respond(32'h11111111, 0);

        issue(2'd1, 5'd9, 32'h0, 0);
        idle();
        step(1, 2'd0, 5'd3, 32'hA5, 1, 0, 1, 0, 32'h77777777);
        chk("ovl_ld", o_wdata, 32'h77777777);
        idle();
        chk("ovl_reg", o_wdata, 32'hA5);

        issue(2'd1, 5'd10, 32'h0, 0);
        idle(); idle(); idle(); idle();
        chk("tmo_pulse", 32'(o_to), 32'd1);
        respond(32'h99999999, 0);

        issue(2'd1, 5'd11, 32'h0, 0);
        idle(); idle(); idle();
        respond(32'hABCD0123, 0);
        chk("exp_resp", 32'(o_to), 32'd0);

        issue(2'd3, 5'd0, 32'h42, 1);
        idle();
        chk("dummy_wr", 32'(o_dm), 32'd1);

        issue(2'd1, 5'd12, 32'h0, 0);
        idle();
        do_reset();

        for (int i = 0; i < 400; i++) begin
            r_rv = h_valid && h_kind != 0 && ($urandom_range(0, 9) < 3);
            r_en = pred_ready(r_rv) && ($urandom_range(0, 3) != 0);
            step(r_en, 2'($urandom_range(0, 3)), 5'($urandom),
                 $urandom, 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 r_rv, 1'($urandom_range(0, 4) == 0), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
